negedge_serial_rx: RTL and testbench
====================================

Name: negedge_serial_rx

Overview:
- Receiver for a single-wire serial frame whose transmitter launches one bit per clock on the falling edge of clk.
- Samples the line on the rising edge, half a cycle after launch, so it samples mid-bit.
- Checks framing and parity, then delivers each byte through a valid/ready output backed by a 2-entry buffer.
- Sits between the pad-side negedge launch register chain and on-chip consumers.

Parameters:
- DATA_W, 8: payload bits per frame, sent LSB first.
- PARITY_EN, 1: 1 = an even-parity bit follows the data; 0 = no parity bit.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sdi  in  1  serial data. Idles high; changes only on the falling edge of clk.
- m_data  out  DATA_W  received payload, head of the buffer.
- m_valid  out  1  m_data holds a valid byte.
- m_ready  in  1  consumer accepts; a transfer occurs on a rising edge where m_valid && m_ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled 0.
- parity_err  out  1  one-cycle pulse: parity mismatch.
- overflow  out  1  one-cycle pulse: good frame dropped because the buffer was full.

Behaviour:
- Clock and reset:
  - One clock; reset is asynchronous and active-low.
  - While rst_n = 0: state = IDLE, bit counter = 0, buffer empty, m_valid = 0, m_data = 0, all error pulses 0.
  - Reset asserted mid-frame abandons the frame; no pulses are raised for it.
- Frame format: start bit (0), then DATA_W data bits (LSB first), then a parity bit if PARITY_EN, then a stop bit (1). One bit per clk cycle.
- State machine:
  - IDLE: sdi = 0 at a rising edge → DATA, count = 0.
  - DATA: shift sdi into the shift register at position count. After DATA_W samples → PARITY if PARITY_EN, else STOP.
  - PARITY: sample the parity bit; record mismatch = (XOR of data) ^ sdi → STOP.
  - STOP:
    - sdi = 1 and no mismatch → push the payload, go to IDLE.
    - sdi = 1 and mismatch → parity_err pulse, discard the payload, go to IDLE.
    - sdi = 0 → frame_err pulse, discard the payload, go to WAIT_IDLE. frame_err takes priority over parity_err; only one pulse is raised per frame.
  - WAIT_IDLE: stay until sdi = 1 is sampled, then go to IDLE. This stops a held-low (break) line from being read as back-to-back start bits.
- Back-to-back frames: the rising edge after the stop-bit sample may carry the next start bit, and it is accepted. Frames need zero idle gap.
- Latency: m_valid rises at the rising edge that samples the stop bit, registered and visible in the following cycle. For DATA_W = 8 with parity, that is 10 edges after the start-bit edge, counting the start-bit edge as edge 0.
- Buffer: 2-entry FIFO, first in first out.
  - Push when full with no pop: drop the frame and raise an overflow pulse.
  - Push and pop on the same edge while full: both are accepted, there is no overflow, and the occupancy stays 2.
  - Push and pop on the same edge while holding 1 entry: the occupancy stays 1 and m_data advances to the new byte.
  - m_data and m_valid come straight from registers; there is no combinational path from m_ready to m_valid.
- Error outputs are pulses, never sticky. Each pulse is high for exactly the cycle after the deciding edge.

Decomposition:
- Shared package rx_pkg:
  - state enum {IDLE, DATA, PARITY, STOP, WAIT_IDLE};
  - constant FRAME_LEN = 1 + DATA_W + PARITY_EN + 1;
  - counter width function, clog2 of DATA_W.
- Sub-module rx_skid_fifo: 2-entry FIFO with push/pop, full/empty flags and occupancy rules as above. It is instantiated once.
- The FSM, shift register and parity accumulator live in the top module.

Test Plan:
- Good frame: after reset, drive 0xA5 with parity (bit sequence 0,1,0,1,0,0,1,0,1,0,1, with sdi updated on negedges), m_ready = 1 → m_valid high for 1 cycle 10 edges after the start edge, m_data = 0xA5, no error pulses.
- Parity error: 0x3C with parity bit 1 (correct is 0) → parity_err pulses once, m_valid stays 0, next good frame 0x01 is delivered normally.
- Frame error and break: 0x55 with stop bit 0, then sdi held low for 20 cycles, then high → frame_err pulses once, no frames are decoded during the low period; a subsequent 0x7E is received correctly.
- Backpressure and overflow: m_ready = 0, send 0x11, 0x22, 0x33 back-to-back with no gap → overflow pulses on the third frame. Raising m_ready then yields 0x11, then 0x22, then m_valid = 0.
- Simultaneous push/pop while full: buffer holds 0x11 and 0x22; assert m_ready for exactly the stop edge of 0x33 → no overflow, output order 0x11, 0x22, 0x33.
- Async reset mid-frame: pull rst_n low after the 4th data bit of 0xF0, release it, send 0x0F → only 0x0F is delivered, and all outputs read 0 during reset without waiting for a clock edge.

Source files
------------

// File: rtl/rx_pkg.sv
// Shared definitions for the negedge-launched serial receiver.
//   rx_state_e : receiver FSM states
//   frame_len  : total bits per frame (start + data + optional parity + stop)
//   cnt_w      : width of the data-bit counter
package rx_pkg;

  localparam int unsigned DATA_W_DEF    = 8;
  localparam bit          PARITY_EN_DEF = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StData,
    StParity,
    StStop,
    StWaitIdle
  } rx_state_e;

  function automatic int unsigned frame_len(input int unsigned data_w, input bit parity_en);
    return 1 + data_w + (parity_en ? 1 : 0) + 1;
  endfunction

  localparam int unsigned FRAME_LEN = frame_len(DATA_W_DEF, PARITY_EN_DEF);

  function automatic int unsigned cnt_w(input int unsigned data_w);
    return (data_w > 1) ? $clog2(data_w) : 1;
  endfunction

endpackage

// File: rtl/negedge_serial_rx_if.sv
// Valid/ready byte stream from the receiver to its consumer.
//   m_data  : payload at the head of the receive buffer
//   m_valid : m_data holds a byte
//   m_ready : consumer accepts on a rising edge where m_valid && m_ready
interface negedge_serial_rx_if #(
  parameter int unsigned DATA_W = 8
) ();

  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);

endinterface

// File: rtl/rx_skid_fifo.sv
// Two-entry FIFO between the frame decoder and the valid/ready output.
//   push_i/push_data_i : good frame from the decoder
//   ready_i            : consumer ready; pop happens when valid_o && ready_i
//   data_o/valid_o     : head entry, driven from registers
//   overflow_o         : one-cycle pulse when a push was dropped while full
module rx_skid_fifo #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             ready_i,
  output logic [Width-1:0] data_o,
  output logic             valid_o,
  output logic             overflow_o
);

  logic [Width-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0]       count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             empty, full, pop, push_ok;

  assign empty = (count_q == 2'd0);
  assign full  = (count_q == 2'd2);
  assign pop   = !empty && ready_i;
  // A pop on the same edge frees the slot, so a full buffer still accepts.
  assign push_ok = push_i && (!full || pop);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ovf_d   = push_i && !push_ok;
    case ({push_ok, pop})
      2'b10: begin
        if (empty) head_d = push_data_i;
        else       tail_d = push_data_i;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = push_data_i;
        end else begin
          head_d = tail_q;
          tail_d = push_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign data_o     = head_q;
  assign valid_o    = !empty;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/negedge_serial_rx.sv
// Serial frame receiver. The transmitter launches bits on the falling edge of
// clk; this block samples on the rising edge, i.e. mid-bit.
//   clk, rst_n : clock, async active-low reset
//   sdi        : serial input, idles high
//   m_if       : valid/ready byte output (2-entry buffered)
//   frame_err  : pulse, stop bit sampled low
//   parity_err : pulse, even-parity mismatch
//   overflow   : pulse, good frame dropped because the buffer was full
module negedge_serial_rx
  import rx_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter bit          PARITY_EN = PARITY_EN_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sdi,
  negedge_serial_rx_if.master  m_if,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overflow
);

  localparam int unsigned CntW = cnt_w(DATA_W);

  rx_state_e         state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              mis_q, mis_d;
  logic              frame_err_q, frame_err_d;
  logic              parity_err_q, parity_err_d;
  logic              push;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    mis_d        = mis_q;
    push         = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (!sdi) begin
          state_d = StData;
          cnt_d   = '0;
          mis_d   = 1'b0;
        end
      end
      StData: begin
        // LSB arrives first, so after DATA_W right shifts bit 0 is in place.
        shift_d = {sdi, shift_q[DATA_W-1:1]};
        if (cnt_q == CntW'(DATA_W - 1)) begin
          state_d = PARITY_EN ? StParity : StStop;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StParity: begin
        mis_d   = (^shift_q) ^ sdi;
        state_d = StStop;
      end
      StStop: begin
        if (sdi) begin
          if (mis_q) parity_err_d = 1'b1;
          else       push         = 1'b1;
          state_d = StIdle;
        end else begin
          // Framing error wins over parity; only one pulse per frame.
          frame_err_d = 1'b1;
          state_d     = StWaitIdle;
        end
      end
      StWaitIdle: begin
        // Hold off until the line returns high so a break is not decoded.
        if (sdi) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      shift_q      <= '0;
      mis_q        <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      mis_q        <= mis_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
    end
  end

  rx_skid_fifo #(
    .Width(DATA_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .push_data_i(shift_q),
    .ready_i    (m_if.m_ready),
    .data_o     (m_if.m_data),
    .valid_o    (m_if.m_valid),
    .overflow_o (overflow)
  );

  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;

endmodule

// File: tb/tb_negedge_serial_rx.sv
// Directed bench for negedge_serial_rx with an expected-byte scoreboard.
module tb_negedge_serial_rx;
  import rx_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic sdi;
  logic frame_err, parity_err, overflow;

  negedge_serial_rx_if #(.DATA_W(8)) bus ();

  negedge_serial_rx #(
    .DATA_W   (8),
    .PARITY_EN(1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sdi       (sdi),
    .m_if      (bus),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int fe_cnt = 0;
  int pe_cnt = 0;
  int ov_cnt = 0;
  int xfer_cnt = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Sample 1 time unit before each rising edge.
  always @(negedge clk) begin
    #4;
    if (rst_n) begin
      if (frame_err)  fe_cnt++;
      if (parity_err) pe_cnt++;
      if (overflow)   ov_cnt++;
      if (bus.m_valid && bus.m_ready) begin
        xfer_cnt++;
        n_checks++;
        assert (exp_q.size() != 0) n_pass++;
        else $error("FAIL spurious_xfer: observed byte %0h expected no transfer", bus.m_data);
        if (exp_q.size() != 0) chk("m_data", 32'(bus.m_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      sdi = 1'b1;
    end
  endtask

  // Drives one frame, one bit per falling edge. Returns at the falling edge
  // that launched the stop bit.
  task automatic send(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                      input bit rdy_stop);
    logic [9:0] bits;
    bits = {(^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < FRAME_LEN - 1; i++) begin
      @(negedge clk);
      sdi = bits[i];
    end
    @(negedge clk);
    sdi = ~bad_stop;
    if (rdy_stop) begin
      bus.m_ready = 1'b1;
      @(negedge clk);
      bus.m_ready = 1'b0;
      sdi = 1'b1;
    end
  endtask

  task automatic zero_counts();
    fe_cnt = 0;
    pe_cnt = 0;
    ov_cnt = 0;
    xfer_cnt = 0;
  endtask

  initial begin
    logic [7:0] f0;
    rst_n = 1'b0;
    sdi = 1'b1;
    bus.m_ready = 1'b0;
    #1;
    chk("rst_valid", 32'(bus.m_valid), 0);
    chk("rst_data", 32'(bus.m_data), 0);
    chk("rst_ferr", 32'(frame_err), 0);
    chk("rst_perr", 32'(parity_err), 0);
    chk("rst_ovf", 32'(overflow), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Good frame and latency: valid appears only after the stop-bit edge.
    zero_counts();
    bus.m_ready = 1'b1;
    exp_q.push_back(8'hA5);
    send(8'hA5, 1'b0, 1'b0, 1'b0);
    #4;
    chk("lat_before_stop", 32'(bus.m_valid), 0);
    @(negedge clk);
    #4;
    chk("lat_valid", 32'(bus.m_valid), 1);
    chk("lat_data", 32'(bus.m_data), 32'hA5);
    @(negedge clk);
    #4;
    chk("lat_popped", 32'(bus.m_valid), 0);
    idle(2);
    chk("good_ferr", 32'(fe_cnt), 0);
    chk("good_perr", 32'(pe_cnt), 0);
    chk("good_xfer", 32'(xfer_cnt), 1);

    // Parity error, then a good frame.
    zero_counts();
    send(8'h3C, 1'b1, 1'b0, 1'b0);
    idle(3);
    chk("par_perr", 32'(pe_cnt), 1);
    chk("par_ferr", 32'(fe_cnt), 0);
    chk("par_xfer", 32'(xfer_cnt), 0);
    exp_q.push_back(8'h01);
    send(8'h01, 1'b0, 1'b0, 1'b0);
    idle(3);
    chk("par_next_xfer", 32'(xfer_cnt), 1);
    chk("par_next_perr", 32'(pe_cnt), 1);

    // Frame error followed by a break held low.
    zero_counts();
    send(8'h55, 1'b0, 1'b1, 1'b0);
    repeat (20) begin
      @(negedge clk);
      sdi = 1'b0;
    end
    idle(3);
    chk("brk_ferr", 32'(fe_cnt), 1);
    chk("brk_perr", 32'(pe_cnt), 0);
    chk("brk_xfer", 32'(xfer_cnt), 0);
    exp_q.push_back(8'h7E);
    send(8'h7E, 1'b0, 1'b0, 1'b0);
    idle(3);
    chk("brk_next_xfer", 32'(xfer_cnt), 1);

    // Backpressure and overflow, back-to-back frames.
    zero_counts();
    bus.m_ready = 1'b0;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send(8'h11, 1'b0, 1'b0, 1'b0);
    send(8'h22, 1'b0, 1'b0, 1'b0);
    send(8'h33, 1'b0, 1'b0, 1'b0);
    idle(3);
    chk("bp_ovf", 32'(ov_cnt), 1);
    chk("bp_valid", 32'(bus.m_valid), 1);
    chk("bp_head", 32'(bus.m_data), 32'h11);
    bus.m_ready = 1'b1;
    idle(4);
    chk("bp_drained", 32'(bus.m_valid), 0);
    chk("bp_xfer", 32'(xfer_cnt), 2);
    chk("bp_queue", 32'(exp_q.size()), 0);
    bus.m_ready = 1'b0;

    // Push and pop on the same edge while full.
    zero_counts();
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    send(8'h11, 1'b0, 1'b0, 1'b0);
    send(8'h22, 1'b0, 1'b0, 1'b0);
    send(8'h33, 1'b0, 1'b0, 1'b1);
    idle(2);
    chk("pp_ovf", 32'(ov_cnt), 0);
    chk("pp_xfer", 32'(xfer_cnt), 1);
    chk("pp_head", 32'(bus.m_data), 32'h22);
    bus.m_ready = 1'b1;
    idle(4);
    chk("pp_xfer_all", 32'(xfer_cnt), 3);
    chk("pp_valid", 32'(bus.m_valid), 0);
    chk("pp_queue", 32'(exp_q.size()), 0);
    bus.m_ready = 1'b0;

    // Async reset mid-frame with a byte waiting in the buffer.
    zero_counts();
    send(8'h99, 1'b0, 1'b0, 1'b0);
    idle(2);
    chk("pre_rst_data", 32'(bus.m_data), 32'h99);
    f0 = 8'hF0;
    @(negedge clk);
    sdi = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sdi = f0[i];
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.m_valid), 0);
    chk("arst_data", 32'(bus.m_data), 0);
    chk("arst_ferr", 32'(frame_err), 0);
    chk("arst_perr", 32'(parity_err), 0);
    chk("arst_ovf", 32'(overflow), 0);
    @(negedge clk);
    sdi = 1'b1;
    rst_n = 1'b1;
    idle(2);
    zero_counts();
    bus.m_ready = 1'b1;
    exp_q.push_back(8'h0F);
    send(8'h0F, 1'b0, 1'b0, 1'b0);
    idle(3);
    chk("post_rst_xfer", 32'(xfer_cnt), 1);
    chk("post_rst_queue", 32'(exp_q.size()), 0);
    chk("post_rst_errs", 32'(fe_cnt + pe_cnt + ov_cnt), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
